cpu_store_fifo: RTL and testbench
=================================

# cpu_store_fifo

Memory-mapped store capture buffer attached to the single-cycle CPU's data-memory bus, downstream of the core. It watches every store the CPU issues (`write_enable`, `address_to_mem`, `data_to_mem`), captures word-aligned stores that fall inside a configurable address window, and queues them in a FIFO. A consumer such as a UART or an output logger drains the FIFO over a valid/ready handshake. Overflow is flagged and counted, never stalls the CPU.

## Interface

Parameters:
- BASE_ADDR, 32'hFFFF_0000, window base; low OFS_W+2 bits must be zero
- OFS_W, 4, word-offset width; window covers 2**OFS_W words (64 bytes by default)
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (8 by default)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- write_enable  in  1  CPU store strobe
- address_to_mem  in  32  CPU store byte address
- data_to_mem  in  32  CPU store data
- out_valid  out  1  FIFO head entry is valid
- out_ready  in  1  consumer accepts head entry
- out_offset  out  OFS_W  word offset of head entry within the window
- out_data  out  32  store data of head entry
- count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: at least one hit dropped since last clear
- drop_count  out  8  number of dropped hits, saturates at 255
- clr_overflow  in  1  synchronous clear of overflow and drop_count

## Operation

- hit = write_enable && address_to_mem[31:OFS_W+2] == BASE_ADDR[31:OFS_W+2] && address_to_mem[1:0] == 2'b00.
- Stores outside the window or misaligned stores are ignored and have no effect on any output.
- push = hit. pop = out_valid && out_ready.
- Storage: circular buffer of DEPTH entries {offset, data}. Write pointer and read pointer are DEPTH_LOG2+1 bits wide; the extra MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
- A push is accepted when count < DEPTH, or when count == DEPTH and pop occurs in the same cycle. Otherwise the hit is dropped.
- Drop: overflow set to 1; drop_count increments and holds at 255.
- clr_overflow: overflow goes to 0 and drop_count goes to 0 on the next edge. If a drop occurs in the same cycle as clr_overflow, the drop wins: overflow = 1 and drop_count = 1.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push and pop when count == DEPTH: the push is accepted and count stays at DEPTH.
- No bypass. A push into an empty FIFO is not visible until the next cycle.
- Outputs are stable while out_valid is 1 and out_ready is 0.
- When out_valid is 0, out_offset and out_data are don't-care.

## Timing

- Reset, asynchronous and effective immediately: out_valid=0, count=0, overflow=0, drop_count=0, pointers=0, out_offset=0, out_data=0.
- Asserting reset mid-operation discards all queued entries. The first hit after reset deasserts is entry 0.
- Push latency: a hit sampled at edge N makes out_valid=1 and count incremented immediately after edge N. It is visible in cycle N+1.
- Pop: the head is consumed at the edge where out_valid and out_ready are both 1. The next entry, or out_valid=0, follows in the same post-edge cycle.
- FWFT: out_offset and out_data are driven from the head entry combinationally from the registered storage and pointers. No read latency.
- Throughput: one push and one pop per cycle. This matches the CPU's maximum rate of one store per cycle, so the CPU never stalls.
- count, overflow and drop_count are registered outputs.

## Test plan

- Reset then single store: write_enable=1, address 0xFFFF_0008, data 0xDEAD_BEEF for one cycle. Required: next cycle out_valid=1, out_offset=2, out_data=0xDEADBEEF, count=1. Pulse out_ready and the FIFO returns to out_valid=0, count=0.
- Filtering: stores to 0xFFFF_0040 (outside the window), 0xFFFF_0006 (misaligned), 0x0000_0008 (low memory), and a read cycle with write_enable=0. Required: count stays 0, overflow stays 0.
- Fill, overflow and wrap: out_ready=0, stores of data 1..10 to 0xFFFF_0000. Required: count=8, overflow=1, drop_count=2. Drain all and observe data 1..8 in order. Then 8 more pushes and pops with data 11..18 cross the pointer wrap in order.
- Full with simultaneous push and pop: FIFO full, out_ready=1, store data 0x55 in the same cycle. Required: count stays 8, overflow unchanged, 0x55 emerges last.
- Clear collision: overflow=1, drop_count=5; assert clr_overflow together with a dropped store. Required: overflow=1, drop_count=1. A clr_overflow alone next cycle gives overflow=0, drop_count=0. Saturation: 300 drops give drop_count=255.
- Reset mid-stream: 3 entries queued, assert reset asynchronously between clock edges. Required: out_valid and count go to 0 immediately, without waiting for an edge. After release, store 0x77 and the head is 0x77.

Source files
------------

// File: rtl/cpu_store_fifo_if.sv
// Head-of-queue stream from the store capture FIFO to its consumer.
// The master side presents the head entry and the slave side accepts it with out_ready.
interface cpu_store_fifo_if #(
    parameter int OFS_W = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [OFS_W-1:0] out_offset;
    logic [31:0]      out_data;

    modport master (
        output out_valid,
        output out_offset,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_offset,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/cpu_store_fifo.sv
// Captures aligned CPU stores inside an address window into a FWFT FIFO; one-cycle push latency, zero read latency.
// Never stalls the CPU: hits arriving while full (and not popping) are dropped and counted.
module cpu_store_fifo #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          OFS_W      = 4,
    parameter int          DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [31:0]           address_to_mem,
    input  logic [31:0]           data_to_mem,
    cpu_store_fifo_if.master      stream,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [7:0]            drop_count,
    input  logic                  clr_overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE      = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [OFS_W-1:0]    ofs_mem [DEPTH];
    logic [31:0]         dat_mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    logic hit;
    logic pop;
    logic full;
    logic push_acc;
    logic drop;

    assign hit = write_enable
              && (address_to_mem[31:OFS_W+2] == BASE_ADDR[31:OFS_W+2])
              && (address_to_mem[1:0] == 2'b00);

    assign full     = (count == FULL_CNT);
    assign pop      = stream.out_valid && stream.out_ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push_acc = hit && (!full || pop);
    assign drop     = hit && !push_acc;

    assign stream.out_valid  = (count != '0);
    // Outputs read as zero while empty so reset leaves them at a known value.
    assign stream.out_offset = stream.out_valid ? ofs_mem[rd_ptr[DEPTH_LOG2-1:0]] : '0;
    assign stream.out_data   = stream.out_valid ? dat_mem[rd_ptr[DEPTH_LOG2-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push_acc) begin
            ofs_mem[wr_ptr[DEPTH_LOG2-1:0]] <= address_to_mem[OFS_W+1:2];
            dat_mem[wr_ptr[DEPTH_LOG2-1:0]] <= data_to_mem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({push_acc, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear wins and restarts the tally at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end
endmodule

// File: tb/tb_cpu_store_fifo.sv
// Directed bench for cpu_store_fifo with a queue scoreboard of accepted stores.
module tb_cpu_store_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clr_overflow;

    cpu_store_fifo_if #(.OFS_W(4)) sif ();

    cpu_store_fifo #(
        .BASE_ADDR (32'hFFFF_0000),
        .OFS_W     (4),
        .DEPTH_LOG2(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .address_to_mem(address_to_mem),
        .data_to_mem   (data_to_mem),
        .stream        (sif),
        .count         (count),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .clr_overflow  (clr_overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [35:0] sb[$];
    logic        m_ovf;
    logic [7:0]  m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_hit(input logic we, input logic [31:0] a);
        return we && ((a & 32'hFFFF_FFC3) == 32'hFFFF_0000);
    endfunction

    task automatic check_state();
        chk("out_valid", {31'd0, sif.out_valid}, {31'd0, sb.size() > 0});
        chk("count", {28'd0, count}, sb.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_count", {24'd0, drop_count}, {24'd0, m_drop});
    endtask

    // One clock: predict from the current inputs, then check after the edge.
    task automatic cyc();
        logic        p;
        logic        h;
        logic [35:0] e;
        int          sz;
        p  = (sb.size() > 0) && sif.out_ready;
        h  = is_hit(write_enable, address_to_mem);
        sz = sb.size();
        if (p) begin
            e = sb.pop_front();
            chk("head_offset", {28'd0, sif.out_offset}, {28'd0, e[35:32]});
            chk("head_data", sif.out_data, e[31:0]);
        end
        if (h && (sz < 8 || p)) begin
            sb.push_back({address_to_mem[5:2], data_to_mem});
        end else if (h) begin
            m_ovf  = 1'b1;
            m_drop = clr_overflow ? 8'd1 : (m_drop == 8'd255 ? 8'd255 : m_drop + 8'd1);
        end else if (clr_overflow) begin
            m_ovf  = 1'b0;
            m_drop = 8'd0;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        write_enable   = 1'b1;
        address_to_mem = a;
        data_to_mem    = d;
        cyc();
        write_enable   = 1'b0;
    endtask

    task automatic drain();
        sif.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        sif.out_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        write_enable   = 1'b0;
        address_to_mem = 32'd0;
        data_to_mem    = 32'd0;
        clr_overflow   = 1'b0;
        sif.out_ready  = 1'b0;
        m_ovf          = 1'b0;
        m_drop         = 8'd0;
        #12;
        check_state();
        chk("rst_offset", {28'd0, sif.out_offset}, 32'd0);
        chk("rst_data", sif.out_data, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single store and pop
        store(32'hFFFF_0008, 32'hDEAD_BEEF);
        chk("single_valid", {31'd0, sif.out_valid}, 32'd1);
        chk("single_offset", {28'd0, sif.out_offset}, 32'd2);
        chk("single_data", sif.out_data, 32'hDEAD_BEEF);
        chk("single_count", {28'd0, count}, 32'd1);
        sif.out_ready = 1'b1;
        cyc();
        sif.out_ready = 1'b0;
        chk("single_empty", {31'd0, sif.out_valid}, 32'd0);

        // Filtering
        store(32'hFFFF_0040, 32'h1);
        store(32'hFFFF_0006, 32'h2);
        store(32'h0000_0008, 32'h3);
        address_to_mem = 32'hFFFF_0008;
        cyc();
        chk("filter_count", {28'd0, count}, 32'd0);
        chk("filter_ovf", {31'd0, overflow}, 32'd0);

        // Fill, overflow, drain, wrap
        for (int i = 1; i <= 10; i++) store(32'hFFFF_0000, i);
        chk("fill_count", {28'd0, count}, 32'd8);
        chk("fill_ovf", {31'd0, overflow}, 32'd1);
        chk("fill_drops", {24'd0, drop_count}, 32'd2);
        drain();
        sif.out_ready = 1'b1;
        for (int i = 11; i <= 18; i++) store(32'hFFFF_0000 + 32'(4 * (i % 16)), i);
        cyc();
        sif.out_ready = 1'b0;
        chk("wrap_empty", {28'd0, count}, 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) store(32'hFFFF_003C, 32'h100 + i);
        sif.out_ready = 1'b1;
        store(32'hFFFF_0014, 32'h55);
        chk("fullpp_count", {28'd0, count}, 32'd8);
        chk("fullpp_drops", {24'd0, drop_count}, 32'd2);
        for (int i = 0; i < 7; i++) cyc();
        chk("fullpp_last", sif.out_data, 32'h55);
        cyc();
        sif.out_ready = 1'b0;

        // Clear collision and saturation
        clr_overflow = 1'b1;
        cyc();
        clr_overflow = 1'b0;
        for (int i = 0; i < 13; i++) store(32'hFFFF_0010, 32'h200 + i);
        chk("pre_clr_drops", {24'd0, drop_count}, 32'd5);
        clr_overflow = 1'b1;
        store(32'hFFFF_0010, 32'h300);
        chk("collide_ovf", {31'd0, overflow}, 32'd1);
        chk("collide_drops", {24'd0, drop_count}, 32'd1);
        cyc();
        clr_overflow = 1'b0;
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_drops", {24'd0, drop_count}, 32'd0);
        for (int i = 0; i < 300; i++) store(32'hFFFF_0020, i);
        chk("sat_drops", {24'd0, drop_count}, 32'd255);
        drain();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) store(32'hFFFF_0030, 32'h400 + i);
        chk("mid_count", {28'd0, count}, 32'd3);
        #3;
        reset = 1'b1;
        #1;
        sb.delete();
        m_ovf  = 1'b0;
        m_drop = 8'd0;
        chk("async_valid", {31'd0, sif.out_valid}, 32'd0);
        chk("async_count", {28'd0, count}, 32'd0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        store(32'hFFFF_0004, 32'h77);
        chk("post_rst_data", sif.out_data, 32'h77);
        chk("post_rst_offset", {28'd0, sif.out_offset}, 32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
